// File: rtl/seq_monitor.sv
// Sequence monitor for the 0-3-5-7-2-1 counter: acquires lock, flags illegal codes and
// out-of-order steps, and keeps saturating error and completed-cycle counts.
module seq_monitor #(
  parameter int unsigned ERR_W  = 8,
  parameter int unsigned WRAP_W = 8,
  parameter int unsigned LOCK_N = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [2:0]        code,
  input  logic              en,
  input  logic              err_clr,
  output logic              lock,
  output logic              err,
  output logic              illegal,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [2:0]        exp_code
);

  localparam logic [1:0] SEARCH  = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  localparam logic [2:0] LockN = 3'(LOCK_N);

  function automatic logic [2:0] nxt(input logic [2:0] c);
    case (c)
      3'd0:    nxt = 3'd3;
      3'd3:    nxt = 3'd5;
      3'd5:    nxt = 3'd7;
      3'd7:    nxt = 3'd2;
      3'd2:    nxt = 3'd1;
      3'd1:    nxt = 3'd0;
      default: nxt = 3'd0;
    endcase
  endfunction

  logic [1:0]        state_q, state_d;
  logic [2:0]        prev_q, prev_d;
  logic [2:0]        run_q, run_d;
  logic [2:0]        run_inc;
  logic              lock_q, lock_d;
  logic              err_q, err_d;
  logic              illegal_q, illegal_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic [2:0]        exp_code_q, exp_code_d;
  logic              legal, match;

  assign legal   = (code != 3'd4) && (code != 3'd6);
  assign match   = (code == nxt(prev_q));
  assign run_inc = run_q + 3'd1;

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    run_d      = run_q;
    wrap_cnt_d = wrap_cnt_q;
    err_d      = 1'b0;
    illegal_d  = 1'b0;

    if (en) begin
      case (state_q)
        SEARCH: begin
          if (legal) begin
            prev_d  = code;
            run_d   = 3'd0;
            state_d = ACQUIRE;
          end else begin
            illegal_d = 1'b1;
          end
        end
        ACQUIRE: begin
          if (!legal) begin
            illegal_d = 1'b1;
            state_d   = SEARCH;
          end else if (match) begin
            prev_d = code;
            run_d  = run_inc;
            if (run_inc == LockN) state_d = LOCKED;
          end else begin
            prev_d = code;
            run_d  = 3'd0;
          end
        end
        LOCKED: begin
          if (legal && match) begin
            prev_d = code;
            // 1 -> 0 closes one full trip around the sequence
            if (prev_q == 3'd1 && code == 3'd0) wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
          end else begin
            err_d = 1'b1;
            if (legal) begin
              prev_d  = code;
              run_d   = 3'd0;
              state_d = ACQUIRE;
            end else begin
              illegal_d = 1'b1;
              state_d   = SEARCH;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    // Clear takes effect before a same-edge increment
    err_cnt_d = err_clr ? '0 : err_cnt_q;
    if (err_d && (err_cnt_d != '1)) err_cnt_d = err_cnt_d + ERR_W'(1);

    lock_d     = (state_d == LOCKED);
    exp_code_d = (state_d == SEARCH) ? 3'd0 : nxt(prev_d);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= SEARCH;
      prev_q     <= 3'd0;
      run_q      <= 3'd0;
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
      illegal_q  <= 1'b0;
      err_cnt_q  <= '0;
      wrap_cnt_q <= '0;
      exp_code_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      run_q      <= run_d;
      lock_q     <= lock_d;
      err_q      <= err_d;
      illegal_q  <= illegal_d;
      err_cnt_q  <= err_cnt_d;
      wrap_cnt_q <= wrap_cnt_d;
      exp_code_q <= exp_code_d;
    end
  end

  assign lock     = lock_q;
  assign err      = err_q;
  assign illegal  = illegal_q;
  assign err_cnt  = err_cnt_q;
  assign wrap_cnt = wrap_cnt_q;
  assign exp_code = exp_code_q;

endmodule

// File: tb/tb_seq_monitor.sv
// Bench for seq_monitor: directed scenarios plus a random stream, checked against a
// behavioural model of the sequence rules; a second instance has a 2-bit error counter.
module tb_seq_monitor;

  localparam int LockN = 3;

  logic       clk = 1'b0;
  logic       clr;
  logic       en;
  logic       err_clr;
  logic [2:0] code;

  logic       lock, err, illegal;
  logic [7:0] err_cnt, wrap_cnt;
  logic [2:0] exp_code;

  logic       s_lock, s_err, s_illegal;
  logic [1:0] s_err_cnt;
  logic [7:0] s_wrap_cnt;
  logic [2:0] s_exp_code;

  seq_monitor #(.ERR_W(8), .WRAP_W(8), .LOCK_N(LockN)) dut (
    .clk(clk), .clr(clr), .code(code), .en(en), .err_clr(err_clr),
    .lock(lock), .err(err), .illegal(illegal), .err_cnt(err_cnt),
    .wrap_cnt(wrap_cnt), .exp_code(exp_code)
  );

  seq_monitor #(.ERR_W(2), .WRAP_W(8), .LOCK_N(LockN)) dut_sat (
    .clk(clk), .clr(clr), .code(code), .en(en), .err_clr(err_clr),
    .lock(s_lock), .err(s_err), .illegal(s_illegal), .err_cnt(s_err_cnt),
    .wrap_cnt(s_wrap_cnt), .exp_code(s_exp_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = searching, 1 = acquiring, 2 = locked
  int seq[6] = '{0, 3, 5, 7, 2, 1};
  int m_mode, m_prev, m_run, m_wrap, m_e8, m_e2, m_exp;
  int m_lock, m_err, m_ill;

  function automatic int succ(input int c);
    for (int i = 0; i < 6; i++) if (seq[i] == c) return seq[(i + 1) % 6];
    return -1;
  endfunction

  function automatic int sat_inc(input int v, input int w);
    return (v + 1 > (1 << w) - 1) ? (1 << w) - 1 : v + 1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_run = 0; m_wrap = 0; m_e8 = 0; m_e2 = 0;
    m_exp = 0; m_lock = 0; m_err = 0; m_ill = 0;
  endtask

  task automatic model_step(input logic e, input int c, input logic ec);
    bit ok;
    m_err = 0;
    m_ill = 0;
    if (ec) begin m_e8 = 0; m_e2 = 0; end
    if (!e) return;
    ok = succ(c) >= 0;
    if (m_mode == 0) begin
      if (ok) begin m_prev = c; m_run = 0; m_mode = 1; end
      else m_ill = 1;
    end else if (m_mode == 1) begin
      if (!ok) begin m_ill = 1; m_mode = 0; end
      else if (c == succ(m_prev)) begin
        m_run++;
        m_prev = c;
        if (m_run == LockN) m_mode = 2;
      end else begin m_run = 0; m_prev = c; end
    end else begin
      if (ok && c == succ(m_prev)) begin
        if (m_prev == 1 && c == 0) m_wrap = (m_wrap + 1) % 256;
        m_prev = c;
      end else begin
        m_err = 1;
        m_e8 = sat_inc(m_e8, 8);
        m_e2 = sat_inc(m_e2, 2);
        if (ok) begin m_mode = 1; m_run = 0; m_prev = c; end
        else begin m_ill = 1; m_mode = 0; end
      end
    end
    m_lock = (m_mode == 2);
    m_exp  = (m_mode == 0) ? 0 : succ(m_prev);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    check("lock", {31'b0, lock}, m_lock);
    check("err", {31'b0, err}, m_err);
    check("illegal", {31'b0, illegal}, m_ill);
    check("err_cnt", {24'b0, err_cnt}, m_e8);
    check("wrap_cnt", {24'b0, wrap_cnt}, m_wrap);
    check("exp_code", {29'b0, exp_code}, m_exp);
    check("sat_err_cnt", {30'b0, s_err_cnt}, m_e2);
  endtask

  task automatic step(input logic e, input int c, input logic ec);
    en = e;
    code = c[2:0];
    err_clr = ec;
    @(posedge clk);
    model_step(e, c, ec);
    #1;
    check_all();
  endtask

  // Asserts clr away from a clock edge and checks outputs clear without an edge
  task automatic do_reset();
    en = 1'b0;
    err_clr = 1'b0;
    #2;
    clr = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #3;
    clr = 1'b1;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic lock_then_err();
    step(1'b1, 0, 1'b0);
    step(1'b1, 3, 1'b0);
    step(1'b1, 5, 1'b0);
    step(1'b1, 7, 1'b0);
    step(1'b1, 0, 1'b0);  // 7 expects 2
  endtask

  initial begin
    int sat_exp[5] = '{1, 2, 3, 3, 3};
    int cur;
    int c;
    logic e;
    clr = 1'b0;
    en = 1'b0;
    err_clr = 1'b0;
    code = 3'd0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    do_reset();

    // Acquire and run through one full cycle
    step(1'b1, 0, 1'b0);
    step(1'b1, 3, 1'b0);
    step(1'b1, 5, 1'b0);
    check("lock_early", {31'b0, lock}, 0);
    step(1'b1, 7, 1'b0);
    check("lock_4th", {31'b0, lock}, 1);
    step(1'b1, 2, 1'b0);
    step(1'b1, 1, 1'b0);
    step(1'b1, 0, 1'b0);
    check("wrap_first", {24'b0, wrap_cnt}, 1);
    step(1'b1, 3, 1'b0);

    // Out-of-order step while locked, then relock
    step(1'b1, 5, 1'b0);
    step(1'b1, 2, 1'b0);
    check("oo_err", {31'b0, err}, 1);
    check("oo_cnt", {24'b0, err_cnt}, 1);
    step(1'b1, 1, 1'b0);
    step(1'b1, 0, 1'b0);
    step(1'b1, 3, 1'b0);
    check("relock", {31'b0, lock}, 1);

    // Illegal code while locked, then in search
    step(1'b1, 6, 1'b0);
    check("ill_locked", {30'b0, err, illegal}, 3);
    step(1'b1, 4, 1'b0);
    check("ill_search", {30'b0, err, illegal}, 1);
    check("ill_cnt", {24'b0, err_cnt}, 2);

    // Saturation on the 2-bit instance, then clear coinciding with an error
    do_reset();
    for (int k = 0; k < 5; k++) begin
      lock_then_err();
      check("sat_seq", {30'b0, s_err_cnt}, sat_exp[k]);
    end
    step(1'b1, 3, 1'b0);
    step(1'b1, 5, 1'b0);
    step(1'b1, 7, 1'b0);
    step(1'b1, 0, 1'b1);
    check("clr_same_edge", {30'b0, s_err_cnt}, 1);
    check("clr_same_edge8", {24'b0, err_cnt}, 1);

    // Locked with en toggling; en=0 edges carry garbage that must be ignored
    step(1'b1, 3, 1'b0);
    step(1'b1, 5, 1'b0);
    step(1'b1, 7, 1'b0);
    cur = 4;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, seq[cur], 1'b0);
      cur = (cur + 1) % 6;
      step(1'b0, $urandom_range(0, 7), 1'b0);
      check("en_hold_exp", {29'b0, exp_code}, seq[cur]);
    end

    // Reach wrap_cnt=3, drop clr mid-cycle, then relock takes LOCK_N+1 samples
    do_reset();
    for (int i = 0; i < 30 && m_wrap != 3; i++) step(1'b1, seq[i % 6], 1'b0);
    check("wrap_three", {24'b0, wrap_cnt}, 3);
    step(1'b1, 3, 1'b0);
    do_reset();
    step(1'b1, 0, 1'b0);
    step(1'b1, 3, 1'b0);
    step(1'b1, 5, 1'b0);
    check("post_rst_nolock", {31'b0, lock}, 0);
    step(1'b1, 7, 1'b0);
    check("post_rst_lock", {31'b0, lock}, 1);

    // Random stream: mostly the legal sequence with occasional corrupt codes
    cur = 3;
    for (int i = 0; i < 2000; i++) begin
      e = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : seq[(cur + 1) % 6];
      if (e) cur = (cur + 1) % 6;
      step(e, c, $urandom_range(0, 49) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
